// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame decoder.
//   frame_state_t : decoder FSM states
//   err_code_t    : error code reported alongside o_frame_err
//   SYNC_BYTE_DEFAULT : default start-of-frame marker
//   frame_active() : true in the states where the inter-byte timeout runs
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } frame_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_BAD_CHK = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // States in which a frame is partially received and the link may stall.
    function automatic logic frame_active(input frame_state_t s);
        return (s == LEN) || (s == PAYLOAD) || (s == CHECK);
    endfunction

endpackage

// File: rtl/counter.sv
// Saturating up-counter with synchronous clear.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   clear    : return count to zero on the next edge (wins over enable)
//   enable   : count up by one per cycle until MAX_VALUE is reached
//   terminal : high while the count equals MAX_VALUE
module counter #(
    parameter int MAX_VALUE = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (MAX_VALUE > 0) ? $clog2(MAX_VALUE + 1) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !terminal) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign terminal = (count_reg == CW'(MAX_VALUE));

endmodule

// File: rtl/frame_buffer.sv
// Payload buffer: DEPTH x WIDTH register file, one write port and one
// combinational read port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module frame_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                                   clk,
    input  logic                                   we,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] waddr,
    input  logic [WIDTH-1:0]                       wdata,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] raddr,
    output logic [WIDTH-1:0]                       rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] row_we;

    // One-hot row select for the write port.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row_we
            assign row_we[gi] = we && (waddr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (row_we[i]) begin
                mem[i] <= wdata;
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame decoder sitting behind a UART receiver. Hunts for
// SYNC, LEN, payload, CHK frames, buffers the payload, checks the length
// and XOR checksum (LEN xor all payload bytes) and releases only good
// payloads over a valid/ready byte stream.
//   clk          : clock
//   i_reset      : asynchronous active-high reset
//   i_data       : received byte
//   i_data_valid : receiver valid, level-held; one byte per rising edge
//   o_byte       : payload byte (0 when not valid)
//   o_byte_valid : payload byte available
//   i_byte_ready : sink accepts the byte
//   o_last       : marks the final payload byte of a frame
//   o_frame_ok   : 1-cycle pulse when a checksum passes
//   o_frame_err  : 1-cycle pulse when a frame is dropped
//   o_err_code   : 1=bad length, 2=bad checksum, 3=timeout; 0 otherwise
//   o_overrun    : 1-cycle pulse when a byte arrives while draining
module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               MAX_LEN   = 16,
    parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(SYNC_BYTE_DEFAULT),
    parameter int               TIMEOUT   = 100000
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_data_valid,
    output logic [WIDTH-1:0] o_byte,
    output logic             o_byte_valid,
    input  logic             i_byte_ready,
    output logic             o_last,
    output logic             o_frame_ok,
    output logic             o_frame_err,
    output logic [1:0]       o_err_code,
    output logic             o_overrun
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    frame_state_t     state_reg;
    logic             prev_valid_reg;
    logic [IW-1:0]    idx_reg;
    logic [IW-1:0]    last_idx_reg;
    logic [WIDTH-1:0] chk_reg;
    logic             frame_ok_reg;
    logic             frame_err_reg;
    err_code_t        err_code_reg;
    logic             overrun_reg;

    logic             accept;
    logic             in_frame;
    logic             timeout_terminal;
    logic             buf_we;
    logic [WIDTH-1:0] buf_rdata;
    logic             draining;

    // prev_valid resets to 1 so a valid still held across reset release
    // is not mistaken for a fresh byte.
    assign accept   = i_data_valid & ~prev_valid_reg;
    assign in_frame = frame_active(state_reg);
    assign draining = (state_reg == DRAIN);
    assign buf_we   = accept && (state_reg == PAYLOAD);

    // Inter-byte timer: runs only mid-frame, restarts on every byte.
    counter #(
        .MAX_VALUE (TIMEOUT - 1)
    ) u_timeout (
        .clk      (clk),
        .rst      (i_reset),
        .clear    (accept | ~in_frame),
        .enable   (in_frame),
        .terminal (timeout_terminal)
    );

    // Write and read share idx: it walks the payload while filling and
    // walks it again while draining.
    frame_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_reg),
        .wdata (i_data),
        .raddr (idx_reg),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg      <= HUNT;
            prev_valid_reg <= 1'b1;
            idx_reg        <= '0;
            last_idx_reg   <= '0;
            chk_reg        <= '0;
            frame_ok_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_code_reg   <= ERR_NONE;
            overrun_reg    <= 1'b0;
        end else begin
            prev_valid_reg <= i_data_valid;
            frame_ok_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_code_reg   <= ERR_NONE;
            overrun_reg    <= 1'b0;

            case (state_reg)
                HUNT: begin
                    if (accept && (i_data == SYNC_BYTE)) begin
                        state_reg <= LEN;
                    end
                end

                LEN: begin
                    if (accept) begin
                        if ((i_data == '0) || (i_data > WIDTH'(MAX_LEN))) begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_BAD_LEN;
                            state_reg     <= HUNT;
                        end else begin
                            // Store len-1 so end-of-payload and o_last are
                            // a plain equality against idx.
                            last_idx_reg <= IW'(i_data - 1'b1);
                            chk_reg      <= i_data;
                            idx_reg      <= '0;
                            state_reg    <= PAYLOAD;
                        end
                    end else if (timeout_terminal) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TIMEOUT;
                        state_reg     <= HUNT;
                    end
                end

                PAYLOAD: begin
                    if (accept) begin
                        chk_reg <= chk_reg ^ i_data;
                        idx_reg <= idx_reg + 1'b1;
                        if (idx_reg == last_idx_reg) begin
                            state_reg <= CHECK;
                        end
                    end else if (timeout_terminal) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TIMEOUT;
                        state_reg     <= HUNT;
                    end
                end

                CHECK: begin
                    if (accept) begin
                        if (i_data == chk_reg) begin
                            frame_ok_reg <= 1'b1;
                            idx_reg      <= '0;
                            state_reg    <= DRAIN;
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_BAD_CHK;
                            state_reg     <= HUNT;
                        end
                    end else if (timeout_terminal) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TIMEOUT;
                        state_reg     <= HUNT;
                    end
                end

                DRAIN: begin
                    // Bytes arriving now are lost; flag and keep draining.
                    if (accept) begin
                        overrun_reg <= 1'b1;
                    end
                    if (i_byte_ready) begin
                        if (idx_reg == last_idx_reg) begin
                            state_reg <= HUNT;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= HUNT;
                end
            endcase
        end
    end

    // Output byte and last are decoded from registered state, so they stay
    // stable under backpressure and drop to zero immediately on reset.
    assign o_byte_valid = draining;
    assign o_byte       = draining ? buf_rdata : '0;
    assign o_last       = draining && (idx_reg == last_idx_reg);
    assign o_frame_ok   = frame_ok_reg;
    assign o_frame_err  = frame_err_reg;
    assign o_err_code   = err_code_reg;
    assign o_overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_frame_decoder.sv
module tb_uart_frame_decoder;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int TO      = 200;

    logic             clk;
    logic             i_reset;
    logic [WIDTH-1:0] i_data;
    logic             i_data_valid;
    logic [WIDTH-1:0] o_byte;
    logic             o_byte_valid;
    logic             i_byte_ready;
    logic             o_last;
    logic             o_frame_ok;
    logic             o_frame_err;
    logic [1:0]       o_err_code;
    logic             o_overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] byte_q [$];   // {last, data}
    int         stat_q [$];   // 0 = frame ok, 1..3 = error code
    int         ovr_q  [$];
    int         last_status_cyc = -1;

    int         ready_mode = 0; // 0: always ready, 1: low 20 then alternate, 2: never
    int         bp_cnt     = 0;
    logic [7:0] tx [$];
    int         acc_cyc    = 0;
    int         t_acc      = 0;

    uart_frame_decoder #(
        .WIDTH     (WIDTH),
        .MAX_LEN   (MAX_LEN),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_last       (o_last),
        .o_frame_ok   (o_frame_ok),
        .o_frame_err  (o_frame_err),
        .o_err_code   (o_err_code),
        .o_overrun    (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents output.
    task automatic monitor();
        logic       hold_pending;
        logic [7:0] held_byte;
        logic       held_last;
        logic [8:0] e;
        int         code;
        int         es;
        hold_pending = 1'b0;
        held_byte    = '0;
        held_last    = 1'b0;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                hold_pending = 1'b0;
                continue;
            end
            if (hold_pending) begin
                check("hold_valid", int'(o_byte_valid), 1);
                check("hold_byte", int'(o_byte), int'(held_byte));
                check("hold_last", int'(o_last), int'(held_last));
            end
            hold_pending = o_byte_valid && !i_byte_ready;
            held_byte    = o_byte;
            held_last    = o_last;

            if (o_byte_valid && i_byte_ready) begin
                $display("xfer byte=%02h last=%0d", o_byte, o_last);
                if (byte_q.size() == 0) begin
                    unexpected("unexpected_byte", int'(o_byte));
                end else begin
                    e = byte_q.pop_front();
                    check("byte_data", int'(o_byte), int'(e[7:0]));
                    check("byte_last", int'(o_last), int'(e[8]));
                end
            end

            if (o_frame_ok || o_frame_err) begin
                check("ok_err_exclusive", int'(o_frame_ok & o_frame_err), 0);
                code = o_frame_ok ? 0 : int'(o_err_code);
                $display("status ok=%0d err=%0d code=%0d cyc=%0d", o_frame_ok, o_frame_err, o_err_code, cyc);
                last_status_cyc = cyc;
                if (stat_q.size() == 0) begin
                    unexpected("unexpected_status", code);
                end else begin
                    es = stat_q.pop_front();
                    check("status_code", code, es);
                end
            end else begin
                check("err_code_idle", int'(o_err_code), 0);
            end

            if (o_overrun) begin
                $display("overrun cyc=%0d", cyc);
                if (ovr_q.size() == 0) unexpected("unexpected_overrun", 1);
                else void'(ovr_q.pop_front());
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: i_byte_ready = 1'b1;
                1: begin
                    i_byte_ready = (bp_cnt >= 20) ? bp_cnt[0] : 1'b0;
                    bp_cnt++;
                end
                default: i_byte_ready = 1'b0;
            endcase
        end
    endtask

    task automatic watchdog();
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    endtask

    // Drive a byte now (just after a clock edge), valid held for 'hold' cycles.
    task automatic send_now(input logic [7:0] d, input int hold);
        i_data       = d;
        i_data_valid = 1'b1;
        acc_cyc      = cyc + 1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        i_data_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        send_now(d, hold);
    endtask

    task automatic send_tx(input int hold);
        foreach (tx[i]) send_byte(tx[i], hold);
    endtask

    // tx holds SYNC, LEN, payload..., CHK: expect ok then the payload bytes.
    task automatic expect_payload();
        stat_q.push_back(0);
        for (int i = 2; i < tx.size() - 1; i++) begin
            byte_q.push_back({(i == tx.size() - 2), tx[i]});
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000 && !(byte_q.size() == 0 && stat_q.size() == 0 &&
                             ovr_q.size() == 0 && !o_byte_valid)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) unexpected("idle_timeout", n);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte"},      int'(o_byte), 0);
        check({tag, "_valid"},     int'(o_byte_valid), 0);
        check({tag, "_last"},      int'(o_last), 0);
        check({tag, "_ok"},        int'(o_frame_ok), 0);
        check({tag, "_err"},       int'(o_frame_err), 0);
        check({tag, "_code"},      int'(o_err_code), 0);
        check({tag, "_overrun"},   int'(o_overrun), 0);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_data       = 8'hA5;
        i_data_valid = 1'b1;   // held across reset release: must not count
        i_byte_ready = 1'b1;
        fork
            monitor();
            ready_drv();
            watchdog();
        join_none

        // Reset state, then a valid held through release is ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        i_reset = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        i_data_valid = 1'b0;
        tx = '{8'h01, 8'h7E, 8'h7F};
        send_tx(1);
        repeat (10) @(posedge clk);

        // Good frame.
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        expect_payload(); send_tx(1); wait_idle();

        // Bad checksum then a good frame.
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        stat_q.push_back(2); send_tx(1); wait_idle();
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        expect_payload(); send_tx(1); wait_idle();

        // Length bounds and hunting through junk.
        tx = '{8'hA5, 8'h00};
        stat_q.push_back(1); send_tx(1); wait_idle();
        tx = '{8'hA5, 8'h11};
        stat_q.push_back(1); send_tx(1); wait_idle();
        tx = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        stat_q.push_back(0); byte_q.push_back({1'b1, 8'h7E});
        send_tx(1); wait_idle();
        tx = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        tx.push_back(8'h10);
        expect_payload(); send_tx(1); wait_idle();

        // Timeout: error exactly TO cycles after the last accepted byte.
        tx = '{8'hA5, 8'h02, 8'h10};
        stat_q.push_back(3); send_tx(1);
        t_acc = acc_cyc;
        wait_idle();
        check("timeout_latency", last_status_cyc - t_acc, TO);

        // Byte landing on the terminal cycle beats the timeout.
        tx = '{8'hA5, 8'h02, 8'h10};
        send_tx(1);
        t_acc = acc_cyc;
        while (cyc < t_acc + TO - 1) begin @(posedge clk); #1; end
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        expect_payload();
        send_now(8'h20, 1);
        send_byte(8'h32, 1);
        wait_idle();

        // Backpressure: ready low 20 cycles, then alternating.
        ready_mode = 2;
        tx = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        expect_payload(); send_tx(1);
        bp_cnt = 0; ready_mode = 1;
        wait_idle();
        ready_mode = 0;

        // Overrun during drain; drain completes intact.
        ready_mode = 2;
        tx = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
        expect_payload(); send_tx(1);
        ovr_q.push_back(1); ovr_q.push_back(1);
        send_byte(8'hA5, 1);
        send_byte(8'h02, 3);
        ready_mode = 0;
        wait_idle();

        // Valid held 100 cycles per byte: one accept each.
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        expect_payload(); send_tx(100); wait_idle();

        // Asynchronous reset mid-payload.
        tx = '{8'hA5, 8'h05, 8'h01, 8'h02};
        send_tx(1);
        @(posedge clk); #3;
        i_reset = 1'b1;
        #1;
        check_all_zero("rst_payload");
        repeat (2) @(posedge clk); #1;
        i_reset = 1'b0;
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        expect_payload(); send_tx(1); wait_idle();

        // Asynchronous reset mid-drain drops valid without a clock edge.
        ready_mode = 2;
        tx = '{8'hA5, 8'h01, 8'h55, 8'h54};
        stat_q.push_back(0); send_tx(1);
        repeat (3) @(posedge clk); #1;
        check("drain_valid_pre_reset", int'(o_byte_valid), 1);
        check("drain_byte_pre_reset", int'(o_byte), 8'h55);
        #2;
        i_reset = 1'b1;
        #1;
        check_all_zero("rst_drain");
        repeat (2) @(posedge clk); #1;
        i_reset = 1'b0;
        ready_mode = 0;
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        expect_payload(); send_tx(1); wait_idle();

        check("byte_q_left", byte_q.size(), 0);
        check("stat_q_left", stat_q.size(), 0);
        check("ovr_q_left", ovr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
